// File: rtl/lfsr_pkg.sv
// Shared types and defaults for the LFSR BIST controller.
// Controller states, the default LFSR width and the default Galois tap mask.
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam int LFSR_N_DEFAULT = 20;

  // x^20 + x^3 + 1 style mask: XOR into stage 2, plus the wrap into the MSB.
  localparam logic [LFSR_N_DEFAULT-1:0] LFSR_TAPS_DEFAULT = 20'h80004;

  // Fallback mask for widths other than the default: stage 2 plus the MSB.
  function automatic logic [63:0] default_taps(input int n);
    logic [63:0] m;
    m        = '0;
    m[2]     = 1'b1;
    m[n-1]   = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Galois LFSR register with a serial-load path (feedback bypassed) and a
// single-step path; load has priority over step.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int            N    = LFSR_N_DEFAULT,
  parameter logic [N-1:0]  TAPS = N'(LFSR_TAPS_DEFAULT)
) (
  input  logic         clk,
  input  logic         r,
  input  logic         load,
  input  logic         step,
  input  logic         sin,
  output logic [N-1:0] q
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;
  logic [N-1:0] step_val;

  assign step_val[0] = q_q[N-1];

  generate
    for (genvar gi = 1; gi < N; gi++) begin : g_step
      assign step_val[gi] = q_q[gi-1] ^ (TAPS[gi] & q_q[N-1]);
    end
  endgenerate

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = {q_q[N-2:0], sin};
    end else if (step) begin
      q_d = step_val;
    end
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/lfsr_bist_ctrl.sv
// LFSR pattern-generator BIST controller: serial seed load, handshaked run, done.
// Optional macro LFSR_ZERO_GUARD_EN rejects all-zero seeds with a seed_err pulse.
module lfsr_bist_ctrl
  import lfsr_pkg::*;
#(
  parameter int           N     = LFSR_N_DEFAULT,
  parameter int           CNT_W = 16,
  parameter logic [N-1:0] TAPS  = (N == LFSR_N_DEFAULT) ? N'(LFSR_TAPS_DEFAULT)
                                                        : N'(default_taps(N))
) (
  input  logic             clk,
  input  logic             r,
  input  logic             start,
  input  logic             abort,
  input  logic [N-1:0]     seed,
  input  logic [CNT_W-1:0] count,
  output logic [N-1:0]     pat_data,
  output logic             pat_valid,
  input  logic             pat_ready,
  output logic             busy,
  output logic             done,
  output logic             seed_err
);

  localparam int LCW = $clog2(N);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [LCW-1:0]   load_cnt_q, load_cnt_d;
  logic [N-1:0]     seed_sh_q, seed_sh_d;
  logic             accept;
  logic             core_load;
  logic             core_step;
`ifdef LFSR_ZERO_GUARD_EN
  logic             seed_err_q, seed_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    load_cnt_d  = load_cnt_q;
    seed_sh_d   = seed_sh_q;
    accept      = 1'b0;
    core_load   = 1'b0;
    core_step   = 1'b0;
`ifdef LFSR_ZERO_GUARD_EN
    seed_err_d  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
`ifdef LFSR_ZERO_GUARD_EN
          if (seed == '0) begin
            seed_err_d = 1'b1;
          end else begin
            accept = 1'b1;
          end
`else
          accept = 1'b1;
`endif
        end
        if (accept) begin
          seed_sh_d   = seed;
          remaining_d = count;
          load_cnt_d  = '0;
          state_d     = (count == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        // MSB of the captured seed goes in first so it ends up in stage N-1.
        core_load  = 1'b1;
        seed_sh_d  = {seed_sh_q[N-2:0], 1'b0};
        load_cnt_d = load_cnt_q + LCW'(1);
        if (load_cnt_q == LCW'(N - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (pat_ready) begin
          core_step   = 1'b1;
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides any in-flight load or handshake.
    if (abort && state_q != ST_IDLE) begin
      state_d     = ST_IDLE;
      remaining_d = '0;
      core_load   = 1'b0;
      core_step   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      load_cnt_q  <= '0;
      seed_sh_q   <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      load_cnt_q  <= load_cnt_d;
      seed_sh_q   <= seed_sh_d;
    end
  end

`ifdef LFSR_ZERO_GUARD_EN
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      seed_err_q <= 1'b0;
    end else begin
      seed_err_q <= seed_err_d;
    end
  end
  assign seed_err = seed_err_q;
`else
  assign seed_err = 1'b0;
`endif

  lfsr_core #(
    .N    (N),
    .TAPS (TAPS)
  ) u_core (
    .clk  (clk),
    .r    (r),
    .load (core_load),
    .step (core_step),
    .sin  (seed_sh_q[N-1]),
    .q    (pat_data)
  );

  assign pat_valid = (state_q == ST_RUN);
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_lfsr_bist_ctrl.sv
// Directed scoreboard bench for lfsr_bist_ctrl (N=20, CNT_W=16 defaults).
module tb_lfsr_bist_ctrl;

  localparam int N = 20;
  localparam logic [N-1:0] TB_TAPS = 20'h80004;

  logic          clk = 1'b0;
  logic          r   = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [N-1:0]  seed  = '0;
  logic [15:0]   count = '0;
  logic [N-1:0]  pat_data;
  logic          pat_valid;
  logic          pat_ready = 1'b1;
  logic          busy;
  logic          done;
  logic          seed_err;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];

  lfsr_bist_ctrl dut (
    .clk       (clk),
    .r         (r),
    .start     (start),
    .abort     (abort),
    .seed      (seed),
    .count     (count),
    .pat_data  (pat_data),
    .pat_valid (pat_valid),
    .pat_ready (pat_ready),
    .busy      (busy),
    .done      (done),
    .seed_err  (seed_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] model_step(input logic [N-1:0] q);
    logic [N-1:0] n;
    n[0] = q[N-1];
    for (int i = 1; i < N; i++) n[i] = q[i-1] ^ (TB_TAPS[i] & q[N-1]);
    return n;
  endfunction

  // Drives one run; expected patterns must already be queued in exp_q.
  task automatic run_seq(input string name, input logic [N-1:0] sd, input logic [15:0] cnt,
                         input int stall_at, input int stall_len,
                         output int first_v, output int done_c, output logic [N-1:0] fin);
    int cyc;
    int hs;
    int stalled;
    bit saw_busy_pre;
    first_v = -1; done_c = -1; hs = 0; stalled = 0; fin = '0; saw_busy_pre = 0;
    seed = sd; count = cnt; start = 1'b1; pat_ready = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    if (cnt != 0) chk({name, "_busy_load"}, {31'b0, busy}, 32'd1);
    while (cyc < 300 && done_c < 0) begin
      if (pat_valid && first_v < 0) first_v = cyc;
      if (done) begin
        done_c = cyc;
        fin = pat_data;
      end else if (first_v >= 0 && hs == stall_at && stalled < stall_len) begin
        pat_ready = 1'b0;
        stalled++;
        chk({name, "_valid_held"}, {31'b0, pat_valid}, 32'd1);
        if (exp_q.size() > 0) chk({name, "_stall_data"}, 32'(pat_data), 32'(exp_q[0]));
      end else begin
        pat_ready = 1'b1;
        if (pat_valid) begin
          if (exp_q.size() == 0) chk({name, "_extra_pattern"}, 32'(pat_data), 32'hFFFFFFFF);
          else chk({name, "_pat"}, 32'(pat_data), 32'(exp_q.pop_front()));
          hs++;
        end
      end
      if (cnt == 0 && (busy || pat_valid)) saw_busy_pre = 1;
      if (done_c < 0) begin
        tick();
        cyc++;
      end
    end
    if (done_c < 0) chk({name, "_timeout"}, 32'd0, 32'd1);
    chk({name, "_leftover"}, 32'(exp_q.size()), 32'd0);
    if (cnt == 0) chk({name, "_busy_never"}, {31'b0, saw_busy_pre}, 32'd0);
    pat_ready = 1'b1;
    tick();
    chk({name, "_done_one_cycle"}, {31'b0, done}, 32'd0);
    chk({name, "_idle_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin : main
    int fv;
    int dc;
    logic [N-1:0] fin;
    logic [N-1:0] m;
    bit any_done;

    // Reset state
    #12;
    chk("rst_data", 32'(pat_data), 32'd0);
    chk("rst_valid", {31'b0, pat_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_seed_err", {31'b0, seed_err}, 32'd0);
    @(negedge clk);
    r = 1'b0;
    tick();

    // Seed 1, three patterns: exact cycle timing
    exp_q.push_back(20'h00001); exp_q.push_back(20'h00002); exp_q.push_back(20'h00004);
    run_seq("seed1", 20'h00001, 16'd3, -1, 0, fv, dc, fin);
    chk("seed1_first_valid_cycle", 32'(fv), 32'd21);
    chk("seed1_done_cycle", 32'(dc), 32'd24);
    chk("seed1_final_state", 32'(fin), 32'h00008);
    $display("txn seed1 first_valid=%0d done=%0d final=%05h", fv, dc, fin);

    // MSB feedback: 0x80000 steps to 0x80005
    exp_q.push_back(20'h80000); exp_q.push_back(20'h80005);
    run_seq("msb_fb", 20'h80000, 16'd2, -1, 0, fv, dc, fin);
    chk("msb_fb_final_state", 32'(fin), 32'h8000F);
    $display("txn msb_fb done=%0d final=%05h", dc, fin);

    // Backpressure: 5 stall cycles after the second handshake
    m = 20'h12345;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(m);
      m = model_step(m);
    end
    run_seq("stall", 20'h12345, 16'd5, 2, 5, fv, dc, fin);
    chk("stall_first_valid_cycle", 32'(fv), 32'd21);
    chk("stall_done_cycle", 32'(dc), 32'd31);
    chk("stall_final_state", 32'(fin), 32'(m));
    $display("txn stall done=%0d final=%05h", dc, fin);

    // count == 0 goes straight to DONE
    run_seq("cnt0", 20'h0ABCD, 16'd0, -1, 0, fv, dc, fin);
    chk("cnt0_done_cycle", 32'(dc), 32'd1);
    $display("txn cnt0 done=%0d", dc);

    // Abort on cycle 10 of LOAD
    seed = 20'h55555; count = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    chk("abort_in_load_busy", {31'b0, busy}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_valid", {31'b0, pat_valid}, 32'd0);
    any_done = 0;
    for (int c = 0; c < 30; c++) begin
      if (done || busy || pat_valid) any_done = 1;
      tick();
    end
    chk("abort_no_done", {31'b0, any_done}, 32'd0);
    $display("txn abort_load");
    m = 20'h55555;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(m);
      m = model_step(m);
    end
    run_seq("after_abort", 20'h55555, 16'd4, -1, 0, fv, dc, fin);
    chk("after_abort_done_cycle", 32'(dc), 32'd25);
    $display("txn after_abort done=%0d final=%05h", dc, fin);

    // Abort and start together in IDLE
    seed = 20'h00F0F; count = 16'd2; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_idle_busy", {31'b0, busy}, 32'd0);
    tick();
    chk("abort_start_idle_done", {31'b0, done}, 32'd0);
    $display("txn abort_with_start");

    // Zero seed
`ifdef LFSR_ZERO_GUARD_EN
    seed = '0; count = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_seed_err", {31'b0, seed_err}, 32'd1);
    chk("zero_seed_busy", {31'b0, busy}, 32'd0);
    tick();
    chk("zero_seed_err_pulse", {31'b0, seed_err}, 32'd0);
    chk("zero_seed_busy2", {31'b0, busy}, 32'd0);
    $display("txn zero_seed rejected");
`else
    exp_q.push_back(20'h00000); exp_q.push_back(20'h00000);
    run_seq("zero_seed", 20'h00000, 16'd2, -1, 0, fv, dc, fin);
    chk("zero_seed_done_cycle", 32'(dc), 32'd23);
    chk("zero_seed_err_tied", {31'b0, seed_err}, 32'd0);
    $display("txn zero_seed done=%0d", dc);
`endif

    // Asynchronous reset mid-run
    seed = 20'h00003; count = 16'd8; start = 1'b1; pat_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 22; c++) tick();
    chk("mid_run_valid", {31'b0, pat_valid}, 32'd1);
    #2 r = 1'b1;
    #1;
    chk("async_rst_valid", {31'b0, pat_valid}, 32'd0);
    chk("async_rst_busy", {31'b0, busy}, 32'd0);
    chk("async_rst_data", 32'(pat_data), 32'd0);
    @(negedge clk);
    r = 1'b0;
    tick(); tick();
    chk("post_rst_idle_busy", {31'b0, busy}, 32'd0);
    chk("post_rst_idle_done", {31'b0, done}, 32'd0);
    $display("txn async_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
